// File: rtl/mv_host_port.sv
// mv_host_port: host-side port-B engine that bulk-loads matrix/vector BRAMs, runs the MV controller, and streams the result back
//  clk, rst                          clock, async active-high reset
//  cfg_start/m_words/v_words/iter    job configuration, latched when a job starts from IDLE
//  s_tdata/tvalid/tready/tlast       input stream: matrix words then vector words
//  m_tdata/tvalid/tready/tlast       result stream
//  mbram_*                           matrix BRAM port B (write only)
//  vbram_*                           vector BRAM port B (write on load, read on drain)
//  mv_running/iteration/finish       controller handshake
//  busy, done, err                   status
module mv_host_port #(
    parameter int DW  = 96,
    parameter int MAW = 12,
    parameter int VAW = 10
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           cfg_start,
    input  logic [MAW:0]   cfg_m_words,
    input  logic [VAW-1:0] cfg_v_words,
    input  logic [15:0]    cfg_iteration,
    input  logic [DW-1:0]  s_tdata,
    input  logic           s_tvalid,
    output logic           s_tready,
    input  logic           s_tlast,
    output logic [DW-1:0]  m_tdata,
    output logic           m_tvalid,
    input  logic           m_tready,
    output logic           m_tlast,
    output logic           mbram_en,
    output logic           mbram_we,
    output logic [MAW-1:0] mbram_addr,
    output logic [DW-1:0]  mbram_din,
    output logic           vbram_en,
    output logic           vbram_we,
    output logic [VAW-1:0] vbram_addr,
    output logic [DW-1:0]  vbram_din,
    input  logic [DW-1:0]  vbram_dout,
    output logic           mv_running,
    output logic [15:0]    mv_iteration,
    input  logic           mv_finish,
    output logic           busy,
    output logic           done,
    output logic           err
);
    typedef enum logic [2:0] {IDLE, LOAD_M, LOAD_V, RUN, DRAIN} state_t;
    state_t st, nxt;
    logic [MAW:0]   m_words;
    logic [VAW-1:0] v_words;
    logic [MAW-1:0] cnt;
    logic [VAW-1:0] rd_cnt;
    logic [1:0]     buf_cnt;
    logic           pend, pend_last;
    logic [DW:0]    q0, q1;
    logic           ld_hs, m_last, v_last, rd_last, pop, rd_issue, set_err, wr_m, wr_v;

    assign s_tready     = st == LOAD_M || st == LOAD_V;
    assign ld_hs        = s_tvalid & s_tready;
    assign m_last       = {1'b0, cnt} + 1'b1 == m_words;
    assign v_last       = {1'b0, cnt} + 1'b1 == {{(MAW + 1 - VAW){1'b0}}, v_words};
    assign rd_last      = rd_cnt + 1'b1 == v_words;
    assign wr_m         = st == LOAD_M && s_tvalid;
    assign wr_v         = st == LOAD_V && s_tvalid;
    assign m_tvalid     = st == DRAIN && buf_cnt != 2'd0;
    assign m_tdata      = q0[DW-1:0];
    assign m_tlast      = m_tvalid & q0[DW];
    assign pop          = m_tvalid & m_tready;
    // Issue a read only if the word landing next cycle is guaranteed a free skid slot.
    assign rd_issue     = st == DRAIN && rd_cnt < v_words &&
                          (buf_cnt + {1'b0, pend} < (pop ? 2'd3 : 2'd2));
    assign mbram_en     = wr_m;
    assign mbram_we     = wr_m;
    assign mbram_addr   = wr_m ? cnt : '0;
    assign mbram_din    = wr_m ? s_tdata : '0;
    assign vbram_en     = wr_v | rd_issue;
    assign vbram_we     = wr_v;
    // Loads go to bank 0; results come from the bank the controller wrote last.
    assign vbram_addr   = wr_v ? {1'b0, cnt[VAW-2:0]} :
                          rd_issue ? {mv_iteration[0], rd_cnt[VAW-2:0]} : '0;
    assign vbram_din    = wr_v ? s_tdata : '0;
    assign mv_running   = st == RUN;
    assign busy         = st != IDLE;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) st <= IDLE;
        else     st <= nxt;
    end

    always_comb begin
        nxt     = st;
        set_err = 1'b0;
        case (st)
            IDLE:   if (cfg_start) nxt = LOAD_M;
            LOAD_M: if (ld_hs) begin
                        if (s_tlast) begin
                            nxt     = IDLE;
                            set_err = 1'b1;
                        end else if (m_last) nxt = LOAD_V;
                    end
            LOAD_V: if (ld_hs) begin
                        if (v_last) begin
                            nxt     = RUN;
                            set_err = ~s_tlast;
                        end else if (s_tlast) begin
                            nxt     = IDLE;
                            set_err = 1'b1;
                        end
                    end
            RUN:    if (mv_finish) nxt = DRAIN;
            DRAIN:  if (pop && q0[DW]) nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_words      <= '0;
            v_words      <= '0;
            mv_iteration <= '0;
            cnt          <= '0;
            err          <= 1'b0;
            done         <= 1'b0;
            rd_cnt       <= '0;
            buf_cnt      <= '0;
            pend         <= 1'b0;
            pend_last    <= 1'b0;
            q0           <= '0;
            q1           <= '0;
        end else begin
            done <= pop & q0[DW];
            if (st == IDLE && cfg_start) begin
                m_words      <= cfg_m_words;
                v_words      <= cfg_v_words;
                mv_iteration <= cfg_iteration;
                cnt          <= '0;
                err          <= 1'b0;
            end else if (set_err) begin
                err <= 1'b1;
            end
            if (ld_hs) cnt <= (st == LOAD_M && m_last) ? '0 : cnt + 1'b1;
            if (st != DRAIN) begin
                rd_cnt    <= '0;
                buf_cnt   <= '0;
                pend      <= 1'b0;
                pend_last <= 1'b0;
            end else begin
                pend      <= rd_issue;
                pend_last <= rd_issue & rd_last;
                if (rd_issue) rd_cnt <= rd_cnt + 1'b1;
                buf_cnt <= buf_cnt + {1'b0, pend} - {1'b0, pop};
                // q0 is the head; q1 only ever holds the newer of two entries.
                if (pop)                   q0 <= buf_cnt == 2'd2 ? q1 : {pend_last, vbram_dout};
                else if (buf_cnt == 2'd0)  q0 <= {pend_last, vbram_dout};
                if (!(buf_cnt == 2'd2 && !pop)) q1 <= {pend_last, vbram_dout};
            end
        end
    end
endmodule

// File: tb/tb_mv_host_port.sv
// tb_mv_host_port: directed self-checking bench for mv_host_port with behavioural BRAM models
module tb_mv_host_port;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cfg_start = 1'b0;
    logic [12:0] cfg_m_words = '0;
    logic [9:0]  cfg_v_words = '0;
    logic [15:0] cfg_iteration = '0;
    logic [95:0] s_tdata = '0;
    logic        s_tvalid = 1'b0;
    logic        s_tready;
    logic        s_tlast = 1'b0;
    logic [95:0] m_tdata;
    logic        m_tvalid;
    logic        m_tready = 1'b0;
    logic        m_tlast;
    logic        mbram_en, mbram_we;
    logic [11:0] mbram_addr;
    logic [95:0] mbram_din;
    logic        vbram_en, vbram_we;
    logic [9:0]  vbram_addr;
    logic [95:0] vbram_din;
    logic [95:0] vbram_dout = '0;
    logic        mv_running;
    logic [15:0] mv_iteration;
    logic        mv_finish = 1'b0;
    logic        busy, done, err;

    logic [95:0] mmem [0:4095];
    logic [95:0] vmem [0:1023];
    logic [9:0]  rd_q [$];
    logic [95:0] exp_q [$];
    int          mw_cnt = 0;
    int          vw_cnt = 0;
    int          total = 0;
    int          bad = 0;
    int          first;

    mv_host_port dut (
        .clk(clk), .rst(rst), .cfg_start(cfg_start), .cfg_m_words(cfg_m_words),
        .cfg_v_words(cfg_v_words), .cfg_iteration(cfg_iteration),
        .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tlast(s_tlast),
        .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tlast(m_tlast),
        .mbram_en(mbram_en), .mbram_we(mbram_we), .mbram_addr(mbram_addr), .mbram_din(mbram_din),
        .vbram_en(vbram_en), .vbram_we(vbram_we), .vbram_addr(vbram_addr), .vbram_din(vbram_din),
        .vbram_dout(vbram_dout), .mv_running(mv_running), .mv_iteration(mv_iteration),
        .mv_finish(mv_finish), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mbram_en && mbram_we) begin
            mmem[mbram_addr] <= mbram_din;
            mw_cnt++;
        end
        if (vbram_en) begin
            if (vbram_we) begin
                vmem[vbram_addr] <= vbram_din;
                vw_cnt++;
            end else begin
                vbram_dout <= vmem[vbram_addr];
                rd_q.push_back(vbram_addr);
            end
        end
    end

    function automatic logic [95:0] wd(input int j, input int i);
        return {32'hDA7A_0000 + 32'(j), 32'h0, 32'(i)};
    endfunction

    function automatic logic [95:0] res(input int j, input int i);
        return {32'h05E5_0000 + 32'(j), 32'hFACE, 32'(i)};
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start(input int mw, input int vw, input logic [15:0] it);
        cfg_m_words   = 13'(mw);
        cfg_v_words   = 10'(vw);
        cfg_iteration = it;
        cfg_start     = 1'b1;
        tick();
        cfg_start     = 1'b0;
    endtask

    // Sends mw+vw words back to back; tlast on word index tl, stream stops after an early tlast.
    task automatic load(input int j, input int mw, input int vw, input int tl);
        for (int i = 0; i < mw + vw; i++) begin
            s_tdata  = wd(j, i);
            s_tvalid = 1'b1;
            s_tlast  = (i == tl);
            tick();
            if (i == tl && i != mw + vw - 1) break;
        end
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        s_tdata  = '0;
    endtask

    // Acts as the controller: fills the result bank, then pulses mv_finish.
    task automatic run_phase(input int j, input int vw, input logic [15:0] it);
        int rb;
        rb = it[0] ? 512 : 0;
        for (int i = 0; i < vw; i++) begin
            vmem[rb + i] = res(j, i);
            exp_q.push_back(res(j, i));
        end
        tick();
        tick();
        rd_q.delete();
        mv_finish = 1'b1;
        tick();
        mv_finish = 1'b0;
    endtask

    // mode 0: always ready, 1: alternating, 2: random
    task automatic drain(input string tag, input int n, input int mode, output int fv);
        int k, dones, extra;
        logic stall;
        logic [97:0] held;
        k = 0; dones = 0; extra = 0; stall = 1'b0; held = '0; fv = -1;
        for (int cyc = 0; cyc < 400 && extra < 4; cyc++) begin
            if (done) dones++;
            if (m_tvalid && fv < 0) fv = cyc;
            if (stall) chk({tag, "_stable"}, {m_tvalid, m_tlast, m_tdata}, held);
            m_tready = mode == 0 ? 1'b1 : mode == 1 ? (cyc % 2 == 0) : 1'($urandom_range(0, 1));
            if (m_tvalid && m_tready) begin
                chk({tag, "_data"}, m_tdata, exp_q[k]);
                chk({tag, "_last"}, m_tlast, k == n - 1);
                k++;
                stall = 1'b0;
            end else begin
                stall = m_tvalid;
                held  = {m_tvalid, m_tlast, m_tdata};
            end
            if (k >= n) extra++;
            tick();
        end
        m_tready = 1'b0;
        chk({tag, "_count"}, k, n);
        chk({tag, "_done_pulses"}, dones, 1);
        chk({tag, "_idle"}, busy, 0);
        exp_q.delete();
    endtask

    initial begin
        #1;
        chk("rst_outputs", {s_tready, m_tvalid, m_tlast, mbram_en, mbram_we, vbram_en, vbram_we,
                            mv_running, busy, done, err, mv_iteration, mbram_addr, vbram_addr}, 0);
        chk("rst_data", {m_tdata, mbram_din}, 0);
        tick();
        rst = 1'b0;
        tick();

        // 1: reset in the middle of a matrix load
        start(4, 2, 1);
        chk("load_m_ready", {busy, s_tready}, 2'b11);
        s_tdata = wd(0, 0); s_tvalid = 1'b1;
        tick();
        tick();
        rst = 1'b1;
        #1;
        chk("midrst_outputs", {s_tready, m_tvalid, m_tlast, mbram_en, mbram_we, vbram_en, vbram_we,
                               mv_running, busy, done, err, mv_iteration, mbram_addr, vbram_addr}, 0);
        chk("midrst_data", {m_tdata, mbram_din, vbram_din}, 0);
        tick();
        rst = 1'b0; s_tvalid = 1'b0;
        tick();
        chk("post_rst_idle", {busy, s_tready, mv_running}, 0);

        // 2/3/6: normal load, iteration 1 reads bank 0x200, start during RUN ignored
        mw_cnt = 0; vw_cnt = 0;
        start(4, 2, 1);
        load(1, 4, 2, 5);
        chk("a_run", {mv_running, s_tready, mbram_en, vbram_en, err}, 5'b10000);
        chk("a_writes", {32'(mw_cnt), 32'(vw_cnt)}, {32'd4, 32'd2});
        chk("a_mmem0", mmem[0], wd(1, 0));
        chk("a_mmem3", mmem[3], wd(1, 3));
        chk("a_vmem0", vmem[0], wd(1, 4));
        chk("a_vmem1", vmem[1], wd(1, 5));
        start(9, 3, 7);
        chk("a_busy_start", {busy, err, mv_running, mv_iteration}, {3'b101, 16'd1});
        run_phase(1, 2, 1);
        chk("a_finish_drop", {mv_running, busy}, 2'b01);
        drain("a", 2, 0, first);
        chk("a_first_valid", first, 2);
        chk("a_rd_n", rd_q.size(), 2);
        chk("a_rd0", rd_q[0], 10'h200);
        chk("a_rd1", rd_q[1], 10'h201);

        // 3/4: iteration 2 reads bank 0, alternating ready
        start(1, 8, 2);
        load(2, 1, 8, 8);
        chk("b_run", {mv_running, err}, 2'b10);
        chk("b_vmem7", vmem[7], wd(2, 8));
        run_phase(2, 8, 2);
        drain("b", 8, 1, first);
        chk("b_rd_n", rd_q.size(), 8);
        chk("b_rd0", rd_q[0], 10'h000);
        chk("b_rd7", rd_q[7], 10'h007);

        // missing tlast on the final word: err, job continues; random ready
        start(2, 8, 3);
        load(3, 2, 8, -1);
        chk("c_err_run", {err, mv_running}, 2'b11);
        run_phase(3, 8, 3);
        drain("c", 8, 2, first);
        chk("c_rd0", rd_q[0], 10'h200);
        chk("c_err_kept", err, 1);

        // 5: early tlast on matrix word 2 of 4 aborts the job
        mw_cnt = 0;
        start(4, 2, 5);
        chk("d_err_cleared", err, 0);
        load(4, 4, 2, 1);
        chk("d_abort", {err, busy, s_tready, mv_running}, 4'b1000);
        chk("d_written", {32'(mw_cnt), mmem[1]}, {32'd2, wd(4, 1)});
        tick();
        tick();
        chk("d_no_run", {mv_running, busy}, 0);

        // next start clears err; single-word vector boundary
        start(1, 1, 4);
        chk("e_err_cleared", {err, busy}, 2'b01);
        load(5, 1, 1, 1);
        chk("e_run", {mv_running, err}, 2'b10);
        run_phase(5, 1, 4);
        drain("e", 1, 0, first);
        chk("e_rd0", rd_q[0], 10'h000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
